lsu_wb_master: RTL

LSU_WB_MASTER -- requirements
Module: lsu_wb_master

---
 rtl/titan_lsu_pkg.sv | 33 +++
 rtl/lsu_align.sv | 52 +++++
 rtl/lsu_wb_master.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/titan_lsu_pkg.sv
// Shared encodings for the LSU Wishbone master: access sizes, response
// exception codes, FSM states and the latched request fields.
package titan_lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } lsu_size_e;

  typedef enum logic [1:0] {
    EXC_OK       = 2'b00,
    EXC_MISALIGN = 2'b01,
    EXC_BUS      = 2'b10,
    EXC_TIMEOUT  = 2'b11
  } lsu_exc_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUS  = 2'b01,
    ST_RESP = 2'b10
  } lsu_state_e;

  // Request fields still needed after acceptance; addr/wdata live in the
  // Wishbone output registers themselves.
  typedef struct packed {
    logic      we;
    lsu_size_e size;
    logic      uns;
  } lsu_req_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering for the LSU.
//   Store side: size + addr[1:0] + wdata -> sel, replicated lane data,
//               misaligned/illegal flag.
//   Load side : latched size/unsigned + bus data -> extended load data.
module lsu_align
  import titan_lsu_pkg::*;
(
  input  lsu_size_e   size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [3:0]  sel,
  output logic [31:0] wdat,
  output logic        misaligned,
  input  lsu_size_e   ld_size,
  input  logic        ld_uns,
  input  logic [31:0] bus_rdata,
  output logic [31:0] ldata
);

  always_comb begin
    sel        = 4'h0;
    wdat       = 32'h0;
    misaligned = 1'b0;
    case (size)
      SZ_BYTE: begin
        sel  = 4'h1;
        wdat = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        sel        = addr_lo[1] ? 4'hc : 4'h3;
        wdat       = {2{wdata[15:0]}};
        misaligned = addr_lo[0];
      end
      SZ_WORD: begin
        sel        = 4'hf;
        wdat       = wdata;
        misaligned = |addr_lo;
      end
      default: misaligned = 1'b1;  // size 11 is treated like a misalignment
    endcase
  end

  // Loads always take the low lanes of the returned word.
  always_comb begin
    case (ld_size)
      SZ_BYTE: ldata = {{24{~ld_uns & bus_rdata[7]}}, bus_rdata[7:0]};
      SZ_HALF: ldata = {{16{~ld_uns & bus_rdata[15]}}, bus_rdata[15:0]};
      default: ldata = bus_rdata;
    endcase
  end

endmodule

// File: rtl/lsu_wb_master.sv
// LSU Wishbone master: accepts one load/store at a time from the core,
// runs a single Wishbone classic cycle and returns a one-cycle response.
//   clk/rst        : clock, asynchronous active-low reset
//   req_*          : core request (valid/ready handshake)
//   rsp_*          : one-cycle completion pulse with data and exception code
//   wb_*           : Wishbone master outputs / slave responses
// Misaligned or illegal requests respond with exc=01 without touching the bus.
// TIMEOUT (>=1) is the number of BUS cycles allowed without ack/err.
module lsu_wb_master
  import titan_lsu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic [1:0]  rsp_exc_o,
  output logic [31:0] wb_addr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  lsu_state_e  state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  lsu_req_t    lat, lat_d;
  logic        ready_d, cyc_d, stb_d, we_d, rsp_valid_d;
  logic [3:0]  sel_d;
  logic [31:0] addr_d, dat_d, rdata_d;
  logic [1:0]  exc_d;

  logic [3:0]  a_sel;
  logic [31:0] a_wdat, a_ldata;
  logic        a_mis;

  lsu_align u_align (
    .size       (lsu_size_e'(req_size_i)),
    .addr_lo    (req_addr_i[1:0]),
    .wdata      (req_wdata_i),
    .sel        (a_sel),
    .wdat       (a_wdat),
    .misaligned (a_mis),
    .ld_size    (lat.size),
    .ld_uns     (lat.uns),
    .bus_rdata  (wb_dat_i),
    .ldata      (a_ldata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      lat         <= '0;
      req_ready_o <= 1'b1;
      wb_cyc_o    <= 1'b0;
      wb_stb_o    <= 1'b0;
      wb_we_o     <= 1'b0;
      wb_sel_o    <= 4'h0;
      wb_addr_o   <= 32'h0;
      wb_dat_o    <= 32'h0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= 32'h0;
      rsp_exc_o   <= EXC_OK;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      lat         <= lat_d;
      req_ready_o <= ready_d;
      wb_cyc_o    <= cyc_d;
      wb_stb_o    <= stb_d;
      wb_we_o     <= we_d;
      wb_sel_o    <= sel_d;
      wb_addr_o   <= addr_d;
      wb_dat_o    <= dat_d;
      rsp_valid_o <= rsp_valid_d;
      rsp_rdata_o <= rdata_d;
      rsp_exc_o   <= exc_d;
    end
  end

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    lat_d       = lat;
    cyc_d       = wb_cyc_o;
    stb_d       = wb_stb_o;
    we_d        = wb_we_o;
    sel_d       = wb_sel_o;
    addr_d      = wb_addr_o;
    dat_d       = wb_dat_o;
    rsp_valid_d = 1'b0;
    rdata_d     = rsp_rdata_o;
    exc_d       = rsp_exc_o;
    case (state)
      ST_IDLE: begin
        if (req_valid_i) begin
          lat_d = '{we: req_we_i, size: lsu_size_e'(req_size_i), uns: req_unsigned_i};
          if (a_mis) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rdata_d     = 32'h0;
            exc_d       = EXC_MISALIGN;
          end else begin
            state_d = ST_BUS;
            cnt_d   = '0;
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
            we_d    = req_we_i;
            sel_d   = a_sel;
            addr_d  = req_addr_i;
            dat_d   = a_wdat;
          end
        end
      end
      ST_BUS: begin
        // cnt holds the index of the current BUS cycle, so the abort edge
        // ends the TIMEOUT-th cycle with cyc high.
        if (wb_err_i || wb_ack_i || cnt == CW'(TIMEOUT - 1)) begin
          state_d     = ST_RESP;
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rdata_d     = 32'h0;  // exceptions and stores return zero data
          if (wb_err_i)
            exc_d = EXC_BUS;
          else if (wb_ack_i) begin
            exc_d = EXC_OK;
            if (!lat.we) rdata_d = a_ldata;
          end else
            exc_d = EXC_TIMEOUT;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      default: state_d = ST_IDLE;  // RESP lasts exactly one cycle
    endcase
    ready_d = (state_d == ST_IDLE);
  end

endmodule
